// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for a 5-stage MIPS pipeline.
// Tracks the destination/control info of the instructions in EX, MEM and WB.
// From that state it drives the ID-stage forwarding selects, the load-use
// stall, the branch flush, and two saturating event counters.
module hazard_fwd_ctrl #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_reg_wr,
  input  logic             id_mem_to_reg,
  input  logic             branch_taken,
  output logic             ex_forward_a,
  output logic             ex_forward_b,
  output logic             mem_forward_a,
  output logic             mem_forward_b,
  output logic             stall,
  output logic             flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  logic             ex_reg_wr;
  logic             ex_mem_to_reg;
  logic [REG_W-1:0] ex_dest;
  logic             mem_reg_wr;
  logic             mem_mem_to_reg;
  logic [REG_W-1:0] mem_dest;
  logic             wb_reg_wr;
  logic             wb_mem_to_reg;
  logic [REG_W-1:0] wb_dest;

  logic hit_ex_rs;
  logic hit_ex_rt;
  logic hit_mem_rs;
  logic hit_mem_rt;
  logic load_use;
  logic unused_wb_dbg;

  // Operand match terms, hazard detection and forwarding selects.
  always_comb begin
    hit_ex_rs  = id_use_rs && ex_reg_wr  && (ex_dest  == id_rs) && (id_rs != '0);
    hit_ex_rt  = id_use_rt && ex_reg_wr  && (ex_dest  == id_rt) && (id_rt != '0);
    hit_mem_rs = id_use_rs && mem_reg_wr && (mem_dest == id_rs) && (id_rs != '0);
    hit_mem_rt = id_use_rt && mem_reg_wr && (mem_dest == id_rt) && (id_rt != '0);
    load_use   = ex_mem_to_reg && (hit_ex_rs || hit_ex_rt);

    // A flush outranks a stall; while in reset nothing is reported.
    flush = rst && branch_taken;
    stall = load_use && !flush;

    // A load in EX has no data yet, so it never feeds the EX forward path.
    ex_forward_a  = !flush && hit_ex_rs && !ex_mem_to_reg;
    ex_forward_b  = !flush && hit_ex_rt && !ex_mem_to_reg;
    // The newer EX producer wins over MEM.
    mem_forward_a = !flush && hit_mem_rs && !hit_ex_rs;
    mem_forward_b = !flush && hit_mem_rt && !hit_ex_rt;
  end

  // WB slot is carried only for debug visibility; nothing consumes it here.
  assign unused_wb_dbg = ^{wb_reg_wr, wb_mem_to_reg, wb_dest};

  // Shadow pipeline: advance every cycle, inject a bubble on stall or flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_reg_wr      <= 1'b0;
      ex_mem_to_reg  <= 1'b0;
      ex_dest        <= '0;
      mem_reg_wr     <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      mem_dest       <= '0;
      wb_reg_wr      <= 1'b0;
      wb_mem_to_reg  <= 1'b0;
      wb_dest        <= '0;
    end else begin
      wb_reg_wr      <= mem_reg_wr;
      wb_mem_to_reg  <= mem_mem_to_reg;
      wb_dest        <= mem_dest;
      mem_reg_wr     <= ex_reg_wr;
      mem_mem_to_reg <= ex_mem_to_reg;
      mem_dest       <= ex_dest;
      if (stall || flush) begin
        ex_reg_wr     <= 1'b0;
        ex_mem_to_reg <= 1'b0;
        ex_dest       <= '0;
      end else begin
        ex_reg_wr     <= id_reg_wr;
        ex_mem_to_reg <= id_mem_to_reg;
        ex_dest       <= id_dest;
      end
    end
  end

  // Saturating stall/flush event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (flush && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipelined MIPS datapath.
- Keeps a shadow copy of the destination/control info for the instructions in the EX, MEM and WB stages.
- Drives the ID-stage forwarding mux selects (ex_forward_a/b, mem_forward_a/b), the load-use stall and the branch flush.
- Keeps saturating stall and flush event counters for performance monitoring.

Parameters:
CNT_W, 16, width of the stall_count and flush_count saturating counters
REG_W, 5, register address width

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
id_rs  input  REG_W  Rs field of the instruction in IF/ID
id_rt  input  REG_W  Rt field of the instruction in IF/ID
id_use_rs  input  1  ID instruction reads Rs
id_use_rt  input  1  ID instruction reads Rt
id_dest  input  REG_W  write address selected by RegDst for the ID instruction (Aw)
id_reg_wr  input  1  RegWr of the ID instruction
id_mem_to_reg  input  1  MemToReg of the ID instruction (load)
branch_taken  input  1  branch/jr resolved taken this cycle
ex_forward_a  output  1  select ALUout for the ID-stage A operand
ex_forward_b  output  1  select ALUout for the ID-stage B operand
mem_forward_a  output  1  select Dw for the ID-stage A operand
mem_forward_b  output  1  select Dw for the ID-stage B operand
stall  output  1  hold PC and IF/ID; inject a bubble into ID/EX
flush  output  1  squash IF/ID; inject a bubble into ID/EX
stall_count  output  CNT_W  number of stall cycles, saturating
flush_count  output  CNT_W  number of flush cycles, saturating

Behaviour:
- State: three shadow slots (ex_slot, mem_slot, wb_slot). Each slot holds {reg_wr, mem_to_reg, dest}. A bubble is reg_wr=0, mem_to_reg=0, dest=0.
- Reset (rst=0, async):
  - All slots are bubbles; both counters are 0.
  - Therefore all forward, stall and flush outputs are 0 during and immediately after reset.
  - Reset mid-operation discards all tracked instructions.
- Slot advance each rising clk (rst=1):
  - wb_slot <= mem_slot; mem_slot <= ex_slot.
  - ex_slot <= bubble if stall or flush; otherwise ex_slot <= {id_reg_wr, id_mem_to_reg, id_dest}.
- Match terms (combinational, same cycle):
  - hitEX(x) = ex_slot.reg_wr & ex_slot.dest==x & x!=0.
  - hitMEM(x) = mem_slot.reg_wr & mem_slot.dest==x & x!=0.
- Register $0 never forwards and never stalls.
- Forwarding, A operand (B is identical using id_rt/id_use_rt):
  - ex_forward_a = id_use_rs & hitEX(id_rs) & ~ex_slot.mem_to_reg.
  - mem_forward_a = id_use_rs & hitMEM(id_rs) & ~hitEX(id_rs).
  - EX has priority over MEM: the newer value wins.
- WB-stage hazards are not forwarded. The register file writes in the first half of the cycle, so wb_slot is used only for debug visibility.
- Load-use stall:
  - stall = ~branch_taken & ((id_use_rs & hitEX(id_rs) & ex_slot.mem_to_reg) | (id_use_rt & hitEX(id_rt) & ex_slot.mem_to_reg)).
  - While stall=1, the ex_forward outputs for the stalled operand are 0.
  - Stall lasts exactly 1 cycle. Next cycle the load sits in mem_slot and mem_forward resolves the hazard.
- Flush:
  - flush = branch_taken, combinational.
  - Flush has priority: on simultaneous stall and branch, flush=1 and stall=0.
  - All forward outputs are forced to 0 while flush=1.
- Counters:
  - stall_count increments by 1 on each clk edge with stall=1; flush_count likewise with flush=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Latency: all outputs are combinational from the current slots and ID inputs, so they are valid in the same cycle the consumer is in ID. Slots change only on clk or rst.
- X-safety: id_* inputs are ignored for match purposes when id_use_* is 0.

Test Plan:
1. Release reset. Issue add r3 (reg_wr=1, dest=3); next cycle ID has rs=3, use_rs=1 -> ex_forward_a=1, mem_forward_a=0, stall=0.
2. Producer dest=7, one independent instruction, then consumer rt=7, use_rt=1 -> mem_forward_b=1, ex_forward_b=0.
3. Two back-to-back writers to r4, then consumer rs=4 -> ex_forward_a=1, mem_forward_a=0 (EX priority).
4. lw r5 (mem_to_reg=1), then add using rs=5 -> stall=1 for exactly 1 cycle. Next cycle mem_forward_a=1, stall=0; stall_count=1.
5. Writer with dest=0, then consumer rs=0 -> all forwards 0, stall 0. Also preload stall_count to all-ones via repeated load-use pairs with CNT_W=4 -> count holds at 15 and does not wrap.
6. Load-use hazard coincident with branch_taken=1 -> flush=1, stall=0, forwards 0, flush_count +1, next ex_slot is a bubble. Assert rst=0 mid-sequence -> counters read 0 and outputs 0 immediately, without waiting for clk.
